// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back arbiter for the 32x32 integer register file. EX and MEM each own
// a one-entry buffer; the single register file write port is granted to the
// older full buffer every cycle. The committing write is forwarded onto both
// read ports, and reads that hit a buffered, uncommitted write are flagged
// as pending so the consumer can stall.

module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,

    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,

    output logic            we,
    output logic [AW-1:0]   write_addr_rd,
    output logic [XLEN-1:0] write_data_rd,

    input  logic [AW-1:0]   read_addr_rs1,
    input  logic [AW-1:0]   read_addr_rs2,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    output logic [XLEN-1:0] data_rs1,
    output logic [XLEN-1:0] data_rs2,
    output logic            rs1_pending,
    output logic            rs2_pending,

    output logic            idle
);

    // Buffered write-back entries, one per source.
    logic            ex_full;
    logic [AW-1:0]   ex_buf_rd;
    logic [XLEN-1:0] ex_buf_data;
    logic            mem_full;
    logic [AW-1:0]   mem_buf_rd;
    logic [XLEN-1:0] mem_buf_data;

    // 1: the EX entry is older than the MEM entry. Only meaningful when both
    // buffers are full.
    logic            ex_older;
    logic            ex_older_next;

    logic            ex_grant;
    logic            mem_grant;
    logic            ex_load;
    logic            mem_load;
    logic            ex_keep;
    logic            mem_keep;

    // Oldest-first grant: a lone full buffer always wins, otherwise the age bit decides.
    assign ex_grant  = ex_full & (~mem_full | ex_older);
    assign mem_grant = mem_full & ~ex_grant;

    // A buffer can accept when empty or when it drains at this same edge.
    assign ex_ready  = rst_n & (~ex_full | ex_grant);
    assign mem_ready = rst_n & (~mem_full | mem_grant);

    // Writes to x0 complete the handshake but never enter a buffer.
    assign ex_load   = ex_valid & ex_ready & (ex_rd != '0);
    assign mem_load  = mem_valid & mem_ready & (mem_rd != '0);

    // Entries that remain buffered across the coming edge.
    assign ex_keep   = ex_full & ~ex_grant;
    assign mem_keep  = mem_full & ~mem_grant;

    // Age update: a surviving entry is always older than a newly loaded one;
    // two entries loaded together treat MEM as the older instruction.
    always_comb begin
        ex_older_next = ex_older;
        if (ex_load && mem_load) begin
            ex_older_next = 1'b0;
        end else if (ex_load) begin
            ex_older_next = ~mem_keep;
        end else if (mem_load) begin
            ex_older_next = ex_keep;
        end
    end

    // EX buffer: load on accept, clear when granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_full     <= 1'b0;
            ex_buf_rd   <= '0;
            ex_buf_data <= '0;
        end else if (ex_load) begin
            ex_full     <= 1'b1;
            ex_buf_rd   <= ex_rd;
            ex_buf_data <= ex_data;
        end else if (ex_grant) begin
            ex_full     <= 1'b0;
        end
    end

    // MEM buffer: load on accept, clear when granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_full     <= 1'b0;
            mem_buf_rd   <= '0;
            mem_buf_data <= '0;
        end else if (mem_load) begin
            mem_full     <= 1'b1;
            mem_buf_rd   <= mem_rd;
            mem_buf_data <= mem_data;
        end else if (mem_grant) begin
            mem_full     <= 1'b0;
        end
    end

    // Age bit register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_older <= 1'b0;
        end else begin
            ex_older <= ex_older_next;
        end
    end

    // Commit register: the granted entry drives the write port for one cycle;
    // address and data hold their last values when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we            <= 1'b0;
            write_addr_rd <= '0;
            write_data_rd <= '0;
        end else begin
            we <= ex_grant | mem_grant;
            if (ex_grant) begin
                write_addr_rd <= ex_buf_rd;
                write_data_rd <= ex_buf_data;
            end else if (mem_grant) begin
                write_addr_rd <= mem_buf_rd;
                write_data_rd <= mem_buf_data;
            end
        end
    end

    // Forward the committing write; x0 is never forwarded.
    assign data_rs1 = (we && (write_addr_rd == read_addr_rs1) && (read_addr_rs1 != '0))
                      ? write_data_rd : rf_rs1;
    assign data_rs2 = (we && (write_addr_rd == read_addr_rs2) && (read_addr_rs2 != '0))
                      ? write_data_rd : rf_rs2;

    // Pending: a buffered write to the read register has not reached the port yet.
    assign rs1_pending = (read_addr_rs1 != '0) &&
                         ((ex_full  && (ex_buf_rd  == read_addr_rs1)) ||
                          (mem_full && (mem_buf_rd == read_addr_rs1)));
    assign rs2_pending = (read_addr_rs2 != '0) &&
                         ((ex_full  && (ex_buf_rd  == read_addr_rs2)) ||
                          (mem_full && (mem_buf_rd == read_addr_rs2)));

    assign idle = ~ex_full & ~mem_full & ~we;

endmodule
